// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction fetch bus bundle: memory request/response, decoder queue, redirect
//
// Signals:
//   imem_req/imem_addr      fetch unit -> instruction memory request and word address
//   imem_ack/imem_rdata     instruction memory -> fetch unit completion and instruction word
//   ir/ir_pc/ir_valid       fetch unit -> decoder head entry
//   ir_ready                decoder -> fetch unit accept
//   redirect/redirect_pc    execute -> fetch unit restart request and target
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, ir, ir_pc, ir_valid,
        input  imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_pc, ir_valid,
        output imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with one outstanding request and a 2-entry instruction buffer
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   instr_fetch_if.master: imem_req/imem_addr/imem_ack/imem_rdata memory side,
//         ir/ir_pc/ir_valid/ir_ready decoder side, redirect/redirect_pc restart input
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // r_addr is both the pending request address and, outside DRAIN, the fetch PC.
    // r_pc only carries the redirect target while the stale request drains.
    logic [31:0] r_addr;
    logic [31:0] r_pc;

    // Buffer head lives directly in the output registers; r_bk_* is the second slot.
    logic [31:0] r_ir;
    logic [31:0] r_ir_pc;
    logic        r_ir_valid;
    logic [31:0] r_bk_word;
    logic [31:0] r_bk_pc;
    logic        r_bk_valid;

    logic        w_req;
    logic        w_xfer;
    logic        w_pop;
    logic        w_push;
    logic [1:0]  w_occ_post;
    logic [31:0] w_rpc;

    assign w_rpc  = {bus.redirect_pc[31:2], 2'b00};
    assign w_req  = (r_state == S_REQ) || (r_state == S_DRAIN);
    assign w_xfer = w_req && bus.imem_ack;
    assign w_pop  = r_ir_valid && bus.ir_ready;
    // Redirect wins over push; DRAIN responses are never kept.
    assign w_push = w_xfer && (r_state == S_REQ) && !bus.redirect;

    // Occupancy after this edge; never exceeds 2 because a request is only
    // issued when at most one slot is occupied.
    assign w_occ_post = {1'b0, r_ir_valid} + {1'b0, r_bk_valid}
                      - {1'b0, w_pop} + {1'b0, w_push};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.redirect || (w_occ_post < 2'd2)) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.redirect) begin
                    // Request still in flight: its response must be thrown away.
                    w_state_nxt = w_xfer ? S_REQ : S_DRAIN;
                end else if (w_xfer) begin
                    w_state_nxt = (w_occ_post < 2'd2) ? S_REQ : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_xfer) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= RESET_PC;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_bk_word  <= '0;
            r_bk_pc    <= '0;
            r_bk_valid <= 1'b0;
        end else if (bus.redirect) begin
            // A concurrent pop completes implicitly; ir/ir_pc keep their values.
            r_ir_valid <= 1'b0;
            r_bk_valid <= 1'b0;
            r_pc       <= w_rpc;
            // The address may only move when no request is left pending.
            if (!w_req || w_xfer) begin
                r_addr <= w_rpc;
            end
        end else begin
            if ((r_state == S_DRAIN) && w_xfer) begin
                r_addr <= r_pc;
            end
            if (w_push) begin
                r_addr <= r_addr + 32'd4;
            end

            if (w_pop) begin
                if (r_bk_valid) begin
                    r_ir       <= r_bk_word;
                    r_ir_pc    <= r_bk_pc;
                    r_ir_valid <= 1'b1;
                    r_bk_valid <= w_push;
                    if (w_push) begin
                        r_bk_word <= bus.imem_rdata;
                        r_bk_pc   <= r_addr;
                    end
                end else if (w_push) begin
                    r_ir       <= bus.imem_rdata;
                    r_ir_pc    <= r_addr;
                    r_ir_valid <= 1'b1;
                end else begin
                    r_ir_valid <= 1'b0;
                end
            end else if (w_push) begin
                if (r_ir_valid) begin
                    r_bk_word  <= bus.imem_rdata;
                    r_bk_pc    <= r_addr;
                    r_bk_valid <= 1'b1;
                end else begin
                    r_ir       <= bus.imem_rdata;
                    r_ir_pc    <= r_addr;
                    r_ir_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_addr;
    assign bus.ir        = r_ir;
    assign bus.ir_pc     = r_ir_pc;
    assign bus.ir_valid  = r_ir_valid;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard testbench for instr_fetch with a fetch-stream reference model
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] model_pc;
    bit          drain;
    bit          armed;
    int          n_cmp;
    int          n_err;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One modelled clock edge: drive inputs at negedge, then update the model
    // with what the coming rising edge will do.
    task automatic step(input bit ack, input bit red, input logic [31:0] rpc, input bit rdy);
        bit xfer;
        @(negedge clk);
        bus.imem_ack    = ack;
        bus.redirect    = red;
        bus.redirect_pc = rpc;
        bus.ir_ready    = rdy;
        bus.imem_rdata  = ack ? mem(bus.imem_addr) : 32'hDEAD_BEEF;
        #2;
        xfer = (bus.imem_req === 1'b1) && ack;
        if (red) begin
            exp_q.delete();
            drain    = (bus.imem_req === 1'b1) && !xfer;
            model_pc = {rpc[31:2], 2'b00};
        end else if (xfer) begin
            if (drain) begin
                drain = 1'b0;
            end else begin
                chk("imem_addr_on_xfer", bus.imem_addr, model_pc);
                exp_q.push_back('{pc: model_pc, w: mem(model_pc)});
                model_pc = model_pc + 32'd4;
            end
        end
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        drain    = 1'b0;
        model_pc = RESET_PC;
        #1;
        chk("rst_imem_req",  {31'd0, bus.imem_req}, 32'd0);
        chk("rst_imem_addr", bus.imem_addr, RESET_PC);
        chk("rst_ir_valid",  {31'd0, bus.ir_valid}, 32'd0);
        chk("rst_ir",        bus.ir, 32'd0);
        chk("rst_ir_pc",     bus.ir_pc, 32'd0);
        bus.imem_ack   = 1'b1;   // a late ack during reset must be ignored
        bus.imem_rdata = 32'h1234_5678;
        bus.redirect   = 1'b0;
        bus.ir_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        rst   = 1'b0;
        armed = 1'b1;
        post();
        chk("first_req",      {31'd0, bus.imem_req}, 32'd1);
        chk("first_req_addr", bus.imem_addr, RESET_PC);
    endtask

    // Monitor: every pop must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.ir_valid === 1'b1 && bus.ir_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("ir_pc", bus.ir_pc, exp_q[0].pc);
                    chk("ir",    bus.ir,    exp_q[0].w);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Occupancy checks after every edge.
    initial begin
        forever begin
            post();
            if (armed && !rst) begin
                chk("ir_valid_vs_model", {31'd0, bus.ir_valid}, {31'd0, exp_q.size() != 0});
                if (bus.imem_req === 1'b1 && exp_q.size() > 1) begin
                    chk("occ_plus_outstanding", exp_q.size() + 1, 32'd2);
                end
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        n_cmp = 0;
        n_err = 0;
        armed = 1'b0;
        drain = 1'b0;
        model_pc = RESET_PC;
        rst = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.ir_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Zero-wait memory, always-ready consumer.
        do_reset();
        repeat (8) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Stalled consumer fills both slots, then drains in order.
        do_reset();
        repeat (5) step(1'b1, 1'b0, 32'd0, 1'b0);
        post();
        chk("full_imem_req",  {31'd0, bus.imem_req}, 32'd0);
        chk("full_imem_addr", bus.imem_addr, 32'h8);
        chk("full_head_pc",   bus.ir_pc, 32'h0);
        repeat (6) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Delayed ack with a redirect while the request is pending.
        do_reset();
        step(1'b0, 1'b1, 32'h100, 1'b1);
        post();
        chk("drain_addr_held", bus.imem_addr, 32'h0);
        chk("drain_req",       {31'd0, bus.imem_req}, 32'd1);
        repeat (2) step(1'b0, 1'b0, 32'd0, 1'b1);
        post();
        chk("drain_addr_held2", bus.imem_addr, 32'h0);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        post();
        chk("after_drain_addr",  bus.imem_addr, 32'h100);
        chk("after_drain_valid", {31'd0, bus.ir_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        post();
        chk("first_redirected_pc", bus.ir_pc, 32'h100);
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Redirect coinciding with a transfer; low target bits ignored.
        step(1'b1, 1'b1, 32'h203, 1'b1);
        post();
        chk("redir_xfer_addr",  bus.imem_addr, 32'h200);
        chk("redir_xfer_valid", {31'd0, bus.ir_valid}, 32'd0);
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Address wrap at the top of the space.
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b1, 1'b0, 32'd0, 1'b1);
        post();
        chk("wrap_addr", bus.imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'd0, 1'b1);

        // Reset with a request pending; refetch from RESET_PC.
        do_reset();
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            bit ack;
            bit red;
            bit rdy;
            ack = ($urandom_range(0, 9) < 6);
            red = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                1:       tgt = $urandom_range(0, 255);
                default: tgt = $urandom;
            endcase
            step(ack, red, tgt, rdy);
        end
        repeat (6) step(1'b0, 1'b0, 32'd0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
